// File: rtl/aes_seq_ctrl.sv
// rtl/aes_seq_ctrl.sv - sequencing controller for an iterative AES-128 encryption core
//
// Accepts a key and plaintext blocks over a shared input bus, drives key
// expansion and the round core, counts rounds and holds the result until
// the consumer takes it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   key_valid/ready key handshake on the shared input bus
//   data_valid/ready plaintext handshake on the shared input bus
//   new_key         presented key differs from the stored key
//   kexp_done       key expansion finished (looked at only while expanding)
//   load_key        capture strobe for the key
//   load_data       capture strobe for the plaintext block
//   keylogic_start  select key onto the input-stage output and run expansion
//   pcore_start     select data ^ key onto the input-stage output, start rounds
//   round           current round index, 0..NR
//   round_last      final round in progress
//   busy            controller not idle
//   out_valid/ready ciphertext handshake

module aes_seq_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       new_key,
  input  logic       kexp_done,
  output logic       load_key,
  output logic       load_data,
  output logic       keylogic_start,
  output logic       pcore_start,
  output logic [3:0] round,
  output logic       round_last,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [3:0] NR_W = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_START,
    S_ROUND,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] round_next;
  logic       key_loaded;
  logic       key_loaded_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      round      <= 4'd0;
      key_loaded <= 1'b0;
    end else begin
      state      <= state_next;
      round      <= round_next;
      key_loaded <= key_loaded_next;
    end
  end

  always_comb begin
    state_next      = state;
    round_next      = round;
    key_loaded_next = key_loaded;
    key_ready       = 1'b0;
    data_ready      = 1'b0;
    keylogic_start  = 1'b0;
    pcore_start     = 1'b0;
    out_valid       = 1'b0;

    case (state)
      S_IDLE: begin
        key_ready  = 1'b1;
        // Key wins when both requesters are present; data waits for a usable key.
        data_ready = key_loaded & ~key_valid;
        round_next = 4'd0;
        if (key_valid) begin
          // An unchanged key is already expanded: mark it usable, skip expansion.
          if (new_key) begin
            state_next = S_KEXP;
          end else begin
            key_loaded_next = 1'b1;
          end
        end else if (data_valid && data_ready) begin
          state_next = S_START;
        end
      end

      S_KEXP: begin
        keylogic_start = 1'b1;
        if (kexp_done) begin
          state_next      = S_IDLE;
          key_loaded_next = 1'b1;
        end
      end

      S_START: begin
        pcore_start = 1'b1;
        state_next  = S_ROUND;
        round_next  = 4'd1;
      end

      S_ROUND: begin
        // >= rather than == so a corrupted count can never run past NR or wrap.
        if (round >= NR_W) begin
          state_next = S_DONE;
          round_next = 4'd0;
        end else begin
          round_next = round + 4'd1;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        round_next = 4'd0;
      end
    endcase
  end

  // Strobes are masked while reset is held so nothing is captured during it.
  assign load_key   = key_valid & key_ready & ~rst;
  assign load_data  = data_valid & data_ready & ~rst;
  assign round_last = (state == S_ROUND) && (round == NR_W);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb/tb_aes_seq_ctrl.sv - randomized scoreboard bench for aes_seq_ctrl

module tb_aes_seq_ctrl;

  localparam int NR = 10;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic       key_ready;
  logic       data_valid;
  logic       data_ready;
  logic       new_key;
  logic       kexp_done;
  logic       load_key;
  logic       load_data;
  logic       keylogic_start;
  logic       pcore_start;
  logic [3:0] round;
  logic       round_last;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  aes_seq_ctrl #(.NR(NR)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .new_key        (new_key),
    .kexp_done      (kexp_done),
    .load_key       (load_key),
    .load_data      (load_data),
    .keylogic_start (keylogic_start),
    .pcore_start    (pcore_start),
    .round          (round),
    .round_last     (round_last),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: cycle numbers at which out_valid is expected to rise.
  int exp_ov_q[$];

  // Reference model: key usability, expansion in progress, and the cycle a
  // block was accepted (-1 when no block is in flight).
  bit m_kl   = 0;
  bit m_kexp = 0;
  int m_job  = -1;

  // Directed-stimulus counters checked against DUT strobe activity.
  int n_keylogic = 0;
  int n_load_key = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
    end
  endtask

  // Per-cycle model: expected outputs follow from the phase since acceptance.
  always @(negedge clk) begin
    bit idle_m;
    int ph, e_round, e_rl, e_pc, e_ov, e_dr, e_lk, e_ld;
    if (rst) begin
      m_kl = 0; m_kexp = 0; m_job = -1;
      exp_ov_q.delete();
      chk("rst_key_ready", key_ready, 1);
      chk("rst_data_ready", data_ready, 0);
      chk("rst_load_key", load_key, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_keylogic", keylogic_start, 0);
      chk("rst_pcore", pcore_start, 0);
      chk("rst_round", round, 0);
      chk("rst_round_last", round_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      idle_m  = !m_kexp && (m_job < 0);
      ph      = (m_job >= 0) ? cyc - m_job : 0;
      e_pc    = (ph == 1);
      e_round = (ph >= 2 && ph <= NR + 1) ? ph - 1 : 0;
      e_rl    = (ph == NR + 1);
      e_ov    = (ph >= NR + 2);
      e_dr    = idle_m && m_kl && !key_valid;
      e_lk    = idle_m && key_valid;
      e_ld    = e_dr && data_valid;
      chk("key_ready", key_ready, idle_m);
      chk("data_ready", data_ready, e_dr);
      chk("load_key", load_key, e_lk);
      chk("load_data", load_data, e_ld);
      chk("keylogic_start", keylogic_start, m_kexp);
      chk("pcore_start", pcore_start, e_pc);
      chk("round", round, e_round);
      chk("round_last", round_last, e_rl);
      chk("busy", busy, !idle_m);
      chk("out_valid", out_valid, e_ov);
      if (keylogic_start) n_keylogic++;
      if (load_key) n_load_key++;
      // State advance as seen at the next rising edge.
      if (e_ov && out_ready) m_job = -1;
      if (m_kexp && kexp_done) begin
        m_kexp = 0;
        m_kl   = 1;
      end
      if (e_lk) begin
        if (new_key) m_kexp = 1;
        else         m_kl   = 1;
      end
      if (e_ld) begin
        m_job = cyc;
        exp_ov_q.push_back(cyc + NR + 2);
      end
    end
    cyc++;
  end

  // Output monitor: on each out_valid rise, pop and check its arrival cycle.
  bit prev_ov = 0;
  always @(negedge clk) begin
    int want;
    #2;
    if (rst) begin
      prev_ov = 0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_ov_q.size() == 0) begin
          chk("ov_unexpected", 1, 0);
        end else begin
          want = exp_ov_q.pop_front();
          chk("ov_latency", cyc - 1, want);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic step(input bit kv, input bit dv, input bit nk, input bit kd, input bit ordy);
    key_valid  = kv;
    data_valid = dv;
    new_key    = nk;
    kexp_done  = kd;
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kl0, lk0;
    rst = 1'b1;
    key_valid = 1'b1; data_valid = 1'b1; new_key = 1'b1; kexp_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // No key loaded: data must be refused.
    repeat (4) step(0, 1, 0, 0, 0);

    // New key, expansion takes 5 cycles.
    kl0 = n_keylogic;
    step(1, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("kexp_cycles", n_keylogic - kl0, 5);

    // One block through all rounds; consumer ready once result shows up.
    step(0, 1, 0, 0, 0);
    repeat (NR + 3) step(0, 0, 0, 0, 1);

    // Same key re-presented: load_key pulses, no expansion.
    kl0 = n_keylogic;
    lk0 = n_load_key;
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("same_key_no_kexp", n_keylogic - kl0, 0);
    chk("same_key_load", n_load_key - lk0, 1);

    // Both valids together: key first, data on a following cycle.
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (NR + 2) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    // Drain, then load a key and start a block to reset it at round 6.
    repeat (NR + 6) step(0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && round != 4'd6; i++) step(0, 0, 0, 0, 0);
    chk("reach_round6", round, 6);
    #1 rst = 1'b1;
    #1;
    chk("async_round", round, 0);
    chk("async_busy", busy, 0);
    chk("async_key_ready", key_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) step(0, 1, 0, 0, 0);

    // Reload and finish one more block, then make sure nothing is pending.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (NR + 4) step(0, 0, 0, 0, 1);
    @(negedge clk);
    #3;
    chk("scoreboard_empty", exp_ov_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
